// File: rtl/mmu_context_loader.sv
// Context-switch sequencer: fetches a {lower, upper} descriptor from the process table,
// validates it, and programs one MMU segment entry. Optional macro: MMU_LOADER_TIMEOUT_EN.
module mmu_context_loader #(
  parameter int NUM_SEGMENTS   = 11,
  parameter int ADDR_WIDTH     = 26,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           pid,
  input  logic [ADDR_WIDTH-1:0] table_base,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_valid,
  output logic                  mmu_we,
  output logic [15:0]           mmu_sel,
  output logic [31:0]           mmu_lower,
  output logic [31:0]           mmu_upper,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK_PID, S_RD_LO, S_RD_HI, S_VALIDATE, S_WRITE, S_DONE
  } state_t;

  localparam logic [16:0] NSEG = 17'(NUM_SEGMENTS);

  if (NUM_SEGMENTS < 1 || NUM_SEGMENTS > 65536 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mmu_context_loader: illegal parameter value");
  end

  state_t                  state_reg, state_next;
  logic [15:0]             pid_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [31:0]             lower_reg, upper_reg;
  logic [15:0]             sel_reg;
  logic [31:0]             mmu_lower_reg, mmu_upper_reg;
  logic                    error_reg, error_next;
  logic [1:0]              err_code_reg, err_code_next;
  logic [ADDR_WIDTH-1:0]   entry_addr;
  logic                    pid_ok;
  logic                    timeout_hit;

  // Each descriptor is two words; the sum wraps silently at ADDR_WIDTH.
  assign entry_addr = base_reg + ADDR_WIDTH'({pid_reg, 1'b0});
  assign pid_ok     = ({1'b0, pid_reg} < NSEG);

`ifdef MMU_LOADER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             in_read;

  assign in_read = (state_reg == S_RD_LO) || (state_reg == S_RD_HI);

  // Restarts on every entry into a read state because any state change clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt_reg <= '0;
    else if (in_read && (state_next == state_reg) && !mem_valid)
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    else
      wait_cnt_reg <= '0;
  end

  assign timeout_hit = !mem_valid && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    mem_re        = 1'b0;
    mem_addr      = '0;
    mmu_we        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    error_next    = 1'b0;
    err_code_next = err_code_reg;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next    = S_CHECK_PID;
          err_code_next = 2'd0;
        end
      end
      S_CHECK_PID: begin
        if (!pid_ok) begin
          state_next    = S_IDLE;
          error_next    = 1'b1;
          err_code_next = 2'd1;
        end else begin
          state_next = S_RD_LO;
        end
      end
      S_RD_LO, S_RD_HI: begin
        mem_re   = 1'b1;
        mem_addr = (state_reg == S_RD_HI) ? entry_addr + ADDR_WIDTH'(1) : entry_addr;
        if (mem_valid) begin
          state_next = (state_reg == S_RD_HI) ? S_VALIDATE : S_RD_HI;
        end else if (timeout_hit) begin
          state_next    = S_IDLE;
          error_next    = 1'b1;
          err_code_next = 2'd3;
        end
      end
      S_VALIDATE: begin
        if (lower_reg > upper_reg) begin
          state_next    = S_IDLE;
          error_next    = 1'b1;
          err_code_next = 2'd2;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mmu_we     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MMU-facing values are loaded only on the way into WRITE so they hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pid_reg       <= '0;
      base_reg      <= '0;
      lower_reg     <= '0;
      upper_reg     <= '0;
      sel_reg       <= '0;
      mmu_lower_reg <= '0;
      mmu_upper_reg <= '0;
      error_reg     <= 1'b0;
      err_code_reg  <= 2'd0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        pid_reg  <= pid;
        base_reg <= table_base;
      end
      if (state_reg == S_RD_LO && mem_valid)
        lower_reg <= mem_rdata;
      if (state_reg == S_RD_HI && mem_valid)
        upper_reg <= mem_rdata;
      if (state_reg == S_VALIDATE && state_next == S_WRITE) begin
        sel_reg       <= pid_reg;
        mmu_lower_reg <= lower_reg;
        mmu_upper_reg <= upper_reg;
      end
      error_reg    <= error_next;
      err_code_reg <= err_code_next;
    end
  end

  assign mmu_sel   = sel_reg;
  assign mmu_lower = mmu_lower_reg;
  assign mmu_upper = mmu_upper_reg;
  assign error     = error_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_mmu_context_loader.sv
// Bench for mmu_context_loader: directed vector table, reset/timeout sequences and
// randomized loads checked against a descriptor-level reference model.
module tb_mmu_context_loader;
  localparam int NSEG = 11;
  localparam int AW   = 26;
  localparam int TO   = 4;
  localparam int MAXK = 40;

  logic          clk;
  logic          reset;
  logic          start;
  logic [15:0]   pid;
  logic [AW-1:0] table_base;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_valid;
  logic          mmu_we;
  logic [15:0]   mmu_sel;
  logic [31:0]   mmu_lower;
  logic [31:0]   mmu_upper;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  mmu_context_loader #(.NUM_SEGMENTS(NSEG), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .pid(pid), .table_base(table_base),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mmu_we(mmu_we), .mmu_sel(mmu_sel), .mmu_lower(mmu_lower), .mmu_upper(mmu_upper),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: valid after mem_lat wait cycles of a continuously held request.
  logic [31:0] mem [1024];
  int          mem_lat   = 0;
  logic        mem_stall = 1'b0;
  int          wait_cnt  = 0;

  assign mem_valid = mem_re && !mem_stall && (wait_cnt >= mem_lat);
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_re && !mem_valid) wait_cnt <= wait_cnt + 1;
    else                      wait_cnt <= 0;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]   pid;
    logic [AW-1:0] base;
    logic [31:0]   lo;
    logic [31:0]   hi;
    int            lat;
    int            busy_k;     // cycle after start at which a stray start is driven (0 = none)
    logic [1:0]    exp_code;
    logic          exp_we;
    int            exp_end_k;  // cycle of done or error pulse, counted from the start edge
    logic [AW-1:0] exp_addr;
    int            exp_reads;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] p, input logic [AW-1:0] b, input logic [31:0] lo,
                              input logic [31:0] hi, input int lat, input int bk, input logic [1:0] code,
                              input logic we, input int ek, input logic [AW-1:0] a, input int nr);
    vec_t v;
    v.pid = p; v.base = b; v.lo = lo; v.hi = hi; v.lat = lat; v.busy_k = bk;
    v.exp_code = code; v.exp_we = we; v.exp_end_k = ek; v.exp_addr = a; v.exp_reads = nr;
    return v;
  endfunction

  // Reference model: outcome of one context load from descriptor contents and memory latency.
  function automatic vec_t model(input logic [15:0] p, input logic [AW-1:0] b, input logic [31:0] lo,
                                 input logic [31:0] hi, input int lat, input int bk);
    vec_t v;
    v = mk(p, b, lo, hi, lat, bk, 2'd0, 1'b0, 0, '0, 0);
    if (int'(p) >= NSEG) begin
      v.exp_code = 2'd1; v.exp_end_k = 2;
    end else begin
      v.exp_addr  = AW'(int'(b) + 2 * int'(p));
      v.exp_reads = 2;
      if (lo > hi) begin
        v.exp_code = 2'd2; v.exp_end_k = 5 + 2 * lat;
      end else begin
        v.exp_we = 1'b1; v.exp_end_k = 6 + 2 * lat;
      end
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int            nrd, nwe, ndone, nerr, we_k, end_k;
    logic [AW-1:0] ra0, ra1, a;
    logic [15:0]   sel_s;
    logic [31:0]   lo_s, hi_s;
    logic [1:0]    code_s;
    nrd = 0; nwe = 0; ndone = 0; nerr = 0; we_k = 0; end_k = 0;
    ra0 = '0; ra1 = '0; sel_s = '0; lo_s = '0; hi_s = '0; code_s = '0;
    a = AW'(int'(v.base) + 2 * int'(v.pid));
    mem[a[9:0]] = v.lo;
    a = a + AW'(1);
    mem[a[9:0]] = v.hi;
    mem_lat = v.lat;
    @(negedge clk);
    pid = v.pid; table_base = v.base; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pid = 16'($urandom); table_base = AW'($urandom);
    for (int k = 1; k <= MAXK; k++) begin
      if (k == 1) begin
        chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
        chk({tag, " err_code_cleared"}, 64'(err_code), 64'(0));
      end
      if (mem_re && mem_valid) begin
        if (nrd == 0) ra0 = mem_addr;
        if (nrd == 1) ra1 = mem_addr;
        nrd++;
      end
      if (mmu_we) begin
        nwe++; we_k = k; sel_s = mmu_sel; lo_s = mmu_lower; hi_s = mmu_upper;
      end
      if (done)  begin ndone++; end_k = k; end
      if (error) begin nerr++;  end_k = k; code_s = err_code; end
      if (k == v.busy_k) begin
        start = 1'b1; pid = 16'd2; table_base = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " we_count"},    64'(nwe),   64'(v.exp_we));
    chk({tag, " done_count"},  64'(ndone), 64'(v.exp_code == 2'd0));
    chk({tag, " error_count"}, 64'(nerr),  64'(v.exp_code != 2'd0));
    chk({tag, " end_cycle"},   64'(end_k), 64'(v.exp_end_k));
    chk({tag, " read_count"},  64'(nrd),   64'(v.exp_reads));
    chk({tag, " err_code_held"}, 64'(err_code), 64'(v.exp_code));
    if (v.exp_code != 2'd0) chk({tag, " err_code_pulse"}, 64'(code_s), 64'(v.exp_code));
    if (v.exp_reads == 2) begin
      chk({tag, " addr_lo"}, 64'(ra0), 64'(v.exp_addr));
      chk({tag, " addr_hi"}, 64'(ra1), 64'(AW'(v.exp_addr + AW'(1))));
    end
    if (v.exp_we) begin
      chk({tag, " we_cycle"},  64'(we_k),  64'(v.exp_end_k - 1));
      chk({tag, " mmu_sel"},   64'(sel_s), 64'(v.pid));
      chk({tag, " mmu_lower"}, 64'(lo_s),  64'(v.lo));
      chk({tag, " mmu_upper"}, 64'(hi_s),  64'(v.hi));
    end
    $display("[TB] %s pid=%0d base=0x%0h lat=%0d -> we=%0d end_k=%0d err_code=%0d",
             tag, v.pid, v.base, v.lat, nwe, end_k, err_code);
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    logic [15:0] rp;
    logic [31:0] rlo, rhi;
    int lat, bk;

    reset = 1'b1; start = 1'b0; pid = '0; table_base = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    repeat (2) @(negedge clk);
    chk("reset mem_re",    64'(mem_re),    64'(0));
    chk("reset mem_addr",  64'(mem_addr),  64'(0));
    chk("reset mmu_we",    64'(mmu_we),    64'(0));
    chk("reset mmu_sel",   64'(mmu_sel),   64'(0));
    chk("reset mmu_lower", 64'(mmu_lower), 64'(0));
    chk("reset mmu_upper", 64'(mmu_upper), 64'(0));
    chk("reset busy",      64'(busy),      64'(0));
    chk("reset done",      64'(done),      64'(0));
    chk("reset error",     64'(error),     64'(0));
    chk("reset err_code",  64'(err_code),  64'(0));
    reset = 1'b0;

    tbl[0] = mk(16'd3,     26'h100,     32'h2000,     32'h2FFF, 0, 0, 2'd0, 1'b1,  6, 26'h106, 2);
    tbl[1] = mk(16'd11,    26'h100,     32'h0,        32'h0,    0, 0, 2'd1, 1'b0,  2, 26'h0,   0);
    tbl[2] = mk(16'd5,     26'h200,     32'h5000,     32'h4000, 0, 0, 2'd2, 1'b0,  5, 26'h20A, 2);
    tbl[3] = mk(16'd5,     26'h200,     32'h4000,     32'h4000, 0, 0, 2'd0, 1'b1,  6, 26'h20A, 2);
    tbl[4] = mk(16'd7,     26'h40,      32'h1000,     32'h1FFF, 3, 7, 2'd0, 1'b1, 12, 26'h4E,  2);
    tbl[5] = mk(16'd10,    26'h3FFFFFE, 32'h0,  32'hFFFFFFFF,   1, 0, 2'd0, 1'b1,  8, 26'h12,  2);
    tbl[6] = mk(16'hFFFF,  26'h0,       32'h0,        32'h0,    0, 1, 2'd1, 1'b0,  2, 26'h0,   0);
    tbl[7] = mk(16'd0,     26'h300, 32'hFFFFFFFF,     32'h0,    2, 0, 2'd2, 1'b0,  9, 26'h300, 2);
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while the upper-bound read is outstanding.
    mem_lat = 2;
    @(negedge clk);
    pid = 16'd2; table_base = 26'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset rd_hi mem_re",   64'(mem_re),   64'(1));
    chk("midreset rd_hi mem_addr", 64'(mem_addr), 64'(26'h85));
    #1 reset = 1'b1;
    #1;
    chk("midreset mem_re", 64'(mem_re), 64'(0));
    chk("midreset busy",   64'(busy),   64'(0));
    chk("midreset mmu_we", 64'(mmu_we), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] midreset: reset applied during upper read");
    run_txn(model(16'd0, 26'h80, 32'h10, 32'h20, 0, 0), "after_reset");

`ifdef MMU_LOADER_TIMEOUT_EN
    mem_stall = 1'b1;
    run_txn(mk(16'd1, 26'h0, 32'h0, 32'h0, 0, 0, 2'd3, 1'b0, TO + 2, 26'h0, 0), "timeout");
    mem_stall = 1'b0;
`else
    // Without the timeout the loader keeps waiting until reset.
    mem_stall = 1'b1;
    @(negedge clk);
    pid = 16'd1; table_base = 26'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("stall busy",   64'(busy),   64'(1));
    chk("stall mem_re", 64'(mem_re), 64'(1));
    chk("stall err",    64'(err_code), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_stall = 1'b0;
    chk("stall released busy", 64'(busy), 64'(0));
    $display("[TB] stall: loader waited 30 cycles with no timeout");
`endif

    for (int i = 0; i < 40; i++) begin
      rp  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, NSEG));
      rlo = $urandom;
      rhi = ($urandom_range(0, 3) == 0) ? rlo : $urandom;
      lat = $urandom_range(0, 4);
      bk  = (int'(rp) < NSEG) ? $urandom_range(0, 3) : $urandom_range(0, 1);
      v = model(rp, AW'($urandom), rlo, rhi, lat, bk);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmu_context_loader.md
Name: mmu_context_loader

Overview:
- Context-switch sequencer that programs the MMU segment table on behalf of the kernel.
- On a start command, reads a process descriptor (lower bound word, upper bound word) from the in-memory process table. It validates the descriptor and issues a one-cycle write to the MMU configuration port (we/sel/lower/upper).
- Sits between the CPU's context-switch instruction path and the MMU; it is the writer side of the MMU programming interface.

Parameters:
- NUM_SEGMENTS, 11, number of MMU base/bound entries; a legal pid is 0..NUM_SEGMENTS-1.
- ADDR_WIDTH, 26, width of the memory word address (matches the MMU logical/physical address width).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_valid (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load a context; ignored while busy=1.
- pid  in  16  process/segment selector, sampled with start.
- table_base  in  ADDR_WIDTH  word address of process table entry 0, sampled with start.
- mem_re  out  1  read request, held high until mem_valid.
- mem_addr  out  ADDR_WIDTH  word address of the read.
- mem_rdata  in  32  read data, valid when mem_valid=1.
- mem_valid  in  1  read-complete strobe.
- mmu_we  out  1  one-cycle write strobe to the MMU.
- mmu_sel  out  16  segment index for the MMU write.
- mmu_lower  out  32  base (lower bound) for the MMU write.
- mmu_upper  out  32  bound (upper bound) for the MMU write.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse: context loaded successfully.
- error  out  1  one-cycle pulse: load aborted.
- err_code  out  2  0 none, 1 bad pid, 2 lower>upper, 3 timeout; held until next start.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; latched pid/base/lower/upper are 0.
- States and transitions:
  - IDLE: on start=1, latch pid and table_base, clear err_code, go to CHECK_PID.
  - CHECK_PID: if pid >= NUM_SEGMENTS, pulse error with err_code=1 and go to IDLE; else go to RD_LO.
  - RD_LO: mem_re=1, mem_addr = table_base + 2*pid, truncated to ADDR_WIDTH with wrap-around and no error. On mem_valid, latch mem_rdata as lower and go to RD_HI.
  - RD_HI: mem_re=1, mem_addr = table_base + 2*pid + 1. On mem_valid, latch mem_rdata as upper and go to VALIDATE.
  - VALIDATE: unsigned compare. If lower > upper, pulse error with err_code=2 and go to IDLE; lower == upper is legal. Otherwise go to WRITE.
  - WRITE: mmu_we=1 for exactly one cycle, with mmu_sel = pid, mmu_lower = lower, mmu_upper = upper. Go to DONE.
  - DONE: pulse done for one cycle, then IDLE.
- mmu_sel/mmu_lower/mmu_upper are stable in the WRITE cycle; outside WRITE they hold their last values and mmu_we=0.
- busy=1 in every state except IDLE.
- mem_valid in IDLE, CHECK_PID, VALIDATE, WRITE or DONE is ignored.
- mem_valid arriving in the same cycle mem_re first rises is accepted (zero-wait memory).
- Minimum latency with zero-wait memory: start to mmu_we is 5 cycles; start to done is 6 cycles.
- A start pulse while busy is dropped and does not queue.
- Asynchronous reset mid-operation forces IDLE immediately and deasserts mem_re and mmu_we. No partial MMU write may occur.
- On error, mmu_we is never asserted; the MMU table is unchanged.

Optional Feature:
- Macro MMU_LOADER_TIMEOUT_EN.
- Defined: an 8-bit-or-wider wait counter clears on entry to RD_LO/RD_HI and increments each cycle mem_valid=0. When it reaches TIMEOUT_CYCLES, drop mem_re, pulse error with err_code=3, and go to IDLE.
- Not defined: no counter; RD_LO/RD_HI wait indefinitely and err_code=3 never occurs.

Test Plan:
- Normal load, zero-wait memory: table_base=0x100, pid=3, memory[0x106]=0x2000, [0x107]=0x2FFF -> reads at 0x106 then 0x107, mmu_we one cycle with sel=3/lower=0x2000/upper=0x2FFF, done 6 cycles after start, err_code=0.
- Bad pid: pid=11 with NUM_SEGMENTS=11 -> no mem_re, error pulse, err_code=1, mmu_we never high.
- Inverted bounds: lower=0x5000, upper=0x4000 -> both reads issued, error with err_code=2, no mmu_we. Repeat with lower=upper=0x4000 -> done.
- Wait states and busy start: mem_valid delayed 3 cycles per read, second start during RD_HI -> second start ignored, single mmu_we, done at 12 cycles.
- Reset mid-read: assert reset during RD_HI -> mem_re, busy and mmu_we are 0 the same cycle. A following start with pid=0 loads correctly.
- Timeout (MMU_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=4): mem_valid never asserts -> error with err_code=3 after 4 wait cycles in RD_LO, mem_re drops, busy drops.
